// File: rtl/int_ctrl_if.sv
// Fetch-side and control bundle of the interrupt controller.
// The slave modport is the controller; the master modport is whoever drives it.
interface int_ctrl_if #(
  parameter int NUM_INT = 16
);
  logic [NUM_INT-1:0] int_req;
  logic               gie;
  logic               en_wr;
  logic [NUM_INT-1:0] en_din;
  logic [NUM_INT-1:0] pend_clr;
  logic               stall;
  logic               set_pc;
  logic               int_done;
  logic               halt;
  logic               jal_req;
  logic [15:0]        int_srv_num;
  logic               idle;
  logic               int_active;
  logic [3:0]         act_num;
  logic [NUM_INT-1:0] pend;
  logic [NUM_INT-1:0] en;

  modport slave (
    input  int_req, gie, en_wr, en_din, pend_clr, stall, set_pc, int_done, halt,
    output jal_req, int_srv_num, idle, int_active, act_num, pend, en
  );

  modport master (
    output int_req, gie, en_wr, en_din, pend_clr, stall, set_pc, int_done, halt,
    input  jal_req, int_srv_num, idle, int_active, act_num, pend, en
  );
endinterface

// File: rtl/int_ctrl.sv
// Prioritised vectored interrupt controller feeding the fetch stage with a
// vector JAL request, plus the processor idle hold and its wake-up.
module int_ctrl #(
  parameter int          NUM_INT   = 16,
  parameter logic [15:0] VEC_BASE  = 16'h0100,
  parameter int          VEC_SHIFT = 2
) (
  input logic     clk,
  input logic     reset_b,
  int_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE_ST, REQ_ST, SRV_ST} state_t;

  state_t             state, state_nxt;
  logic [NUM_INT-1:0] s1, s2, s3;
  logic [NUM_INT-1:0] rise, cand, pend_q, en_q, pend_nxt, act_onehot, acc_clr;
  logic [3:0]         winner, act_q, act_nxt;
  logic [15:0]        srv_q, srv_nxt;
  logic               jal_q, jal_nxt, active_q, active_nxt, idle_q, idle_nxt;
  logic               any_cand, acc, pend_act;

  function automatic logic [3:0] lowest_idx(input logic [NUM_INT-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = NUM_INT - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  function automatic logic [15:0] vec_num(input logic [3:0] idx);
    logic [15:0] off;
    off = 16'(idx) << VEC_SHIFT;
    return VEC_BASE + off;
  endfunction

  // Edge detection and candidate selection
  always_comb begin
    rise     = s2 & ~s3;
    cand     = pend_q & en_q;
    any_cand = |cand;
    winner   = lowest_idx(cand);
    acc      = jal_q & ~bus.stall & ~bus.set_pc;
    for (int i = 0; i < NUM_INT; i++) begin
      act_onehot[i] = (act_q == 4'(i));
    end
    pend_act = |(pend_q & act_onehot);
    acc_clr  = acc ? act_onehot : '0;
    // A fresh edge wins over any clear in the same cycle
    pend_nxt = (pend_q & ~(bus.pend_clr | acc_clr)) | rise;
    idle_nxt = bus.halt & ~(bus.gie & any_cand) & (state != REQ_ST);
  end

  always_comb begin
    state_nxt  = state;
    jal_nxt    = jal_q;
    act_nxt    = act_q;
    srv_nxt    = srv_q;
    active_nxt = active_q;
    case (state)
      IDLE_ST: begin
        if (bus.gie && any_cand) begin
          state_nxt = REQ_ST;
          jal_nxt   = 1'b1;
          act_nxt   = winner;
          srv_nxt   = vec_num(winner);
        end
      end
      REQ_ST: begin
        // Fetch has consumed the JAL once acc is seen, so it takes precedence
        if (acc) begin
          state_nxt  = SRV_ST;
          jal_nxt    = 1'b0;
          active_nxt = 1'b1;
        end else if (!bus.gie || !pend_act) begin
          state_nxt = IDLE_ST;
          jal_nxt   = 1'b0;
        end
      end
      SRV_ST: begin
        if (bus.int_done) begin
          state_nxt  = IDLE_ST;
          active_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE_ST;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state    <= IDLE_ST;
      s1       <= '0;
      s2       <= '0;
      s3       <= '0;
      pend_q   <= '0;
      en_q     <= '0;
      jal_q    <= 1'b0;
      act_q    <= '0;
      srv_q    <= '0;
      active_q <= 1'b0;
      idle_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      s1       <= bus.int_req;
      s2       <= s1;
      s3       <= s2;
      pend_q   <= pend_nxt;
      if (bus.en_wr) en_q <= bus.en_din;
      jal_q    <= jal_nxt;
      act_q    <= act_nxt;
      srv_q    <= srv_nxt;
      active_q <= active_nxt;
      idle_q   <= idle_nxt;
    end
  end

  assign bus.jal_req     = jal_q;
  assign bus.int_srv_num = srv_q;
  assign bus.idle        = idle_q;
  assign bus.int_active  = active_q;
  assign bus.act_num     = act_q;
  assign bus.pend        = pend_q;
  assign bus.en          = en_q;

endmodule
